// File: rtl/button_conditioner.sv
// Eight-lane push-button front end: 2-flop synchroniser, debouncer, press/release pulses and auto-repeat events.
// Auto-repeat (HELD->REPEAT with hold counter) is compiled in only when BUTTON_CONDITIONER_AUTOREPEAT_EN is defined.
module button_conditioner #(
    parameter int N_BTN           = 8,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_event
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam int                HOLD_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int                HOLD_W      = $clog2(HOLD_MAX);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_REPEAT
    } state_e;
`else
    typedef enum logic {
        ST_IDLE,
        ST_HELD
    } state_e;
`endif

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_cfg
        $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
        logic            s1_q, s1_d;
        logic            s2_q, s2_d;
        logic [DB_W-1:0] db_cnt_q, db_cnt_d;
        logic            level_q, level_d;
        logic            accept;
        logic            press_q, press_d;
        logic            release_q, release_d;
        logic            event_q, event_d;
        state_e          state_q, state_d;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        logic [HOLD_W-1:0] hold_q, hold_d;
`endif

        // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples;
        // any agreeing sample restarts the count.
        always_comb begin
            // NOTE: every combinational output gets a default first so no path can infer a latch.
            s1_d     = btn_raw[i];
            s2_d     = s1_q;
            level_d  = level_q;
            db_cnt_d = '0;
            accept   = 1'b0;
            if (s2_q != level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    accept  = 1'b1;
                    level_d = s2_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        always_comb begin
            state_d   = state_q;
            press_d   = accept & s2_q;
            release_d = accept & ~s2_q;
            event_d   = 1'b0;
            hold_d    = hold_q;
            case (state_q)
                ST_IDLE: begin
                    if (press_d) begin
                        state_d = ST_HELD;
                        event_d = 1'b1;
                        hold_d  = '0;
                    end
                end
                ST_HELD: begin
                    // Release is checked first so an expiring hold count never fires on the release edge.
                    if (release_d) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else if (hold_q == DELAY_LAST) begin
                        state_d = ST_REPEAT;
                        event_d = 1'b1;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (release_d) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else if (hold_q == PERIOD_LAST) begin
                        event_d = 1'b1;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            endcase
        end
`else
        always_comb begin
            state_d   = state_q;
            press_d   = accept & s2_q;
            release_d = accept & ~s2_q;
            event_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (press_d) begin
                        state_d = ST_HELD;
                        event_d = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (release_d) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
`endif

        always_ff @(posedge clk) begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            if (rst) begin
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                db_cnt_q  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                event_q   <= 1'b0;
                state_q   <= ST_IDLE;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                hold_q    <= '0;
`endif
            end else begin
                s1_q      <= s1_d;
                s2_q      <= s2_d;
                db_cnt_q  <= db_cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                event_q   <= event_d;
                state_q   <= state_d;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                hold_q    <= hold_d;
`endif
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_event[i]   = event_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Table-driven bench for button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
// Expected repeat events depend on whether BUTTON_CONDITIONER_AUTOREPEAT_EN is defined.
module tb_button_conditioner;

    localparam int N  = 8;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        logic         rst;
        logic [N-1:0] raw;
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rls;
        logic [N-1:0] evt;
        string        tag;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_event;

    vec_t vectors[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    button_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_event  (btn_event)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] lane(input int l, input bit c);
        logic [N-1:0] v;
        v    = '0;
        v[l] = c;
        return v;
    endfunction

    task automatic add(input string tag, input logic r, input logic [N-1:0] raw,
                       input logic [N-1:0] lvl, input logic [N-1:0] prs,
                       input logic [N-1:0] rls, input logic [N-1:0] evt);
        vec_t v;
        v.tag = tag;
        v.rst = r;
        v.raw = raw;
        v.lvl = lvl;
        v.prs = prs;
        v.rls = rls;
        v.evt = evt;
        vectors.push_back(v);
    endtask

    // Pops the scoreboard entry for the edge just taken and compares all four outputs.
    task automatic check(input int idx);
        vec_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL vec%0d: scoreboard empty, no expectation for DUT output", idx);
            return;
        end
        e = exp_q.pop_front();
        if ({btn_level, btn_press, btn_release, btn_event} !== {e.lvl, e.prs, e.rls, e.evt}) begin
            n_err++;
            $display("FAIL vec%0d %s: got level=%h press=%h release=%h event=%h, want level=%h press=%h release=%h event=%h",
                     idx, e.tag, btn_level, btn_press, btn_release, btn_event, e.lvl, e.prs, e.rls, e.evt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: all outputs cleared.
        for (int k = 0; k < 2; k++) add("reset", 1'b1, '0, '0, '0, '0, '0);

        // Clean press on lane 0, released before its first repeat point.
        for (int k = 0; k < 18; k++)
            add("clean_press", 1'b0, lane(0, k < 8), lane(0, k >= 5 && k < 13),
                lane(0, k == 5), lane(0, k == 13), lane(0, k == 5));

        // Glitch of DEBOUNCE_CYCLES-1 samples on lane 4 must be rejected.
        for (int k = 0; k < 10; k++)
            add("glitch", 1'b0, lane(4, k < 3), '0, '0, '0, '0);

        // Bounce 1,0,1,0 then steady 1 on lane 2; level accepted 5 edges after last change.
        for (int k = 0; k < 22; k++)
            add("bounce", 1'b0, lane(2, (k < 4) ? (k % 2 == 0) : (k < 12)),
                lane(2, k >= 9 && k < 17), lane(2, k == 9), lane(2, k == 17), lane(2, k == 9));

        // Auto-repeat on lane 1; release accepted exactly on a repeat point (release wins).
        for (int k = 0; k < 41; k++)
            add("auto_repeat", 1'b0, lane(1, k < 31), lane(1, k >= 5 && k < 36),
                lane(1, k == 5), lane(1, k == 36),
                lane(1, k == 5 || (AUTO && (k == 15 || (k > 15 && k < 36 && (k - 15) % RP == 0)))));

        // Lanes 3 and 7 pressed together; lane 3 released 2 cycles before the repeat point.
        for (int k = 0; k < 25; k++)
            add("simultaneous", 1'b0, lane(3, k < 8) | lane(7, k < 15),
                lane(3, k >= 5 && k < 13) | lane(7, k >= 5 && k < 20),
                lane(3, k == 5) | lane(7, k == 5),
                lane(3, k == 13) | lane(7, k == 20),
                lane(3, k == 5) | lane(7, k == 5 || (AUTO && (k == 15 || k == 18))));

        // Reset while lane 5 repeats, cancelling the event due on that edge; held button re-presses.
        for (int k = 0; k < 37; k++)
            add("reset_mid_hold", k == 18, lane(5, k < 27),
                lane(5, (k >= 5 && k < 18) || (k >= 24 && k < 32)),
                lane(5, k == 5 || k == 24), lane(5, k == 32),
                lane(5, k == 5 || k == 24 || (AUTO && k == 15)));

        foreach (vectors[i]) begin
            rst     = vectors[i].rst;
            btn_raw = vectors[i].raw;
            exp_q.push_back(vectors[i]);
            @(posedge clk);
            #1;
            check(i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
